multi_loop_counter: RTL and testbench
=====================================

MULTI_LOOP_COUNTER -- requirements
Module: multi_loop_counter

Interface
REQ-001 SHALL have parameter CH, default 4, number of independent sequencer channels.
REQ-002 SHALL have parameter STEPS, default 16, steps per loop; legal range 2..256.
REQ-003 SHALL have parameter LOOP_W, default 8, width of each channel's loop-count field.
REQ-004 SHALL derive SIDX_W = clog2(STEPS), the step-index width.
REQ-005 SHALL have port Clock, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port nReset, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port Step, input, 1, one-Clock-wide step strobe shared by all channels.
REQ-008 SHALL have port nStart, input, CH, per-channel start; active-low, sampled each Clock.
REQ-009 SHALL have port nStop, input, CH, per-channel abort; active-low, sampled each Clock.
REQ-010 SHALL have port Loops, input, CH*LOOP_W, per-channel loop count; channel c at bits [c*LOOP_W +: LOOP_W]; 0 means loop forever.
REQ-011 SHALL have port Play, output, CH, per-channel playing flag, registered.
REQ-012 SHALL have port StepIdx, output, CH*SIDX_W, per-channel current step in loop, registered.
REQ-013 SHALL have port LoopIdx, output, CH*LOOP_W, per-channel current loop number, registered.
REQ-014 SHALL have port Done, output, CH, per-channel one-Clock pulse on natural completion, registered.

Function
REQ-015 SHALL run each channel as an independent FSM with states IDLE, PLAY; channels share only Clock, nReset, Step.
REQ-016 SHALL apply per-channel priority at each edge: nReset > nStart > nStop > Step > hold.
REQ-017 SHALL, on nStart[c]=0 in any state: latch Loops[c] into L[c], clear StepIdx and LoopIdx, enter PLAY, set Play[c]=1 next cycle; Step ignored that cycle.
REQ-018 SHALL restart continuously while nStart[c] stays low: counters held at 0, Play[c]=1.
REQ-019 SHALL, on nStop[c]=0 (nStart[c]=1): enter IDLE, Play[c]=0, clear StepIdx and LoopIdx, no Done pulse.
REQ-020 SHALL ignore Step in IDLE; counters hold.
REQ-021 SHALL, on Step in PLAY with StepIdx<STEPS-1: increment StepIdx.
REQ-022 SHALL, on Step in PLAY with StepIdx=STEPS-1: set StepIdx=0 and evaluate loop end (REQ-023, REQ-024).
REQ-023 SHALL, at loop end with L[c]!=0 and LoopIdx=L[c]-1: enter IDLE, Play[c]=0, Done[c]=1 for exactly one Clock, and leave LoopIdx unchanged.
REQ-024 SHALL otherwise increment LoopIdx modulo 2^LOOP_W; with L[c]=0 it wraps from all-ones to 0 and play never ends.
REQ-025 SHALL keep Play[c] high for exactly L[c]*STEPS Step strobes after start (L[c]!=0); Play falls and Done pulses on the edge that samples the final Step.
REQ-026 SHALL use only the latched L[c]; Loops changes during PLAY have no effect until the next start.
REQ-027 SHALL give all outputs a latency of one Clock from the sampling edge; no combinational input-to-output path.
REQ-028 SHALL keep Done[c]=0 at all times except the REQ-023 cycle.

Reset
REQ-029 SHALL, on nReset=0 at an edge, put all channels in IDLE with Play=0, Done=0, StepIdx=0, LoopIdx=0, L=0, overriding nStart, nStop and Step, including mid-PLAY.
REQ-030 SHALL require a new nStart after reset release; Step alone never leaves IDLE.

Verification
REQ-031 SHALL cover: CH=4, STEPS=16, ch0 Loops=2, nStart pulse, then 32 Steps -> Play[0] high through Step 31; falls with Done[0] one-cycle pulse after Step 32; StepIdx=0, LoopIdx=1.
REQ-032 SHALL cover: ch1 Loops=0, 300 Steps -> Play[1] stays 1, Done[1] never asserts, LoopIdx ends at 18, StepIdx at 12.
REQ-033 SHALL cover: ch2 Loops=3, nStop after 20 Steps -> Play[2]=0 next cycle, StepIdx=0, LoopIdx=0, no Done; later Steps ignored.
REQ-034 SHALL cover: ch0 Loops=1, nStart and Step in the same cycle -> counters 0 (Step dropped); Loops changed to 5 mid-play -> completion still after 16 Steps.
REQ-035 SHALL cover: two channels playing, nReset=0 for one cycle with Step=1 -> all outputs 0 next cycle; subsequent Steps leave all channels IDLE.

Source files
------------

// File: rtl/multi_loop_counter.sv
// Bank of independent step sequencers: each channel walks STEPS steps per loop
// for a latched number of loops (0 = forever), pulsing Done on natural completion.
module multi_loop_counter #(
  parameter  int CH     = 4,
  parameter  int STEPS  = 16,
  parameter  int LOOP_W = 8,
  localparam int SIDX_W = $clog2(STEPS)
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 Step,
  input  logic [CH-1:0]        nStart,
  input  logic [CH-1:0]        nStop,
  input  logic [CH*LOOP_W-1:0] Loops,
  output logic [CH-1:0]        Play,
  output logic [CH*SIDX_W-1:0] StepIdx,
  output logic [CH*LOOP_W-1:0] LoopIdx,
  output logic [CH-1:0]        Done
);

  typedef enum logic {
    S_IDLE,
    S_PLAY
  } state_e;

  localparam logic [SIDX_W-1:0] LAST_STEP = SIDX_W'(STEPS - 1);

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      state_e              state_q;
      logic [SIDX_W-1:0]   step_q;
      logic [LOOP_W-1:0]   loop_q;
      logic [LOOP_W-1:0]   len_q;
      logic                done_q;

      always_ff @(posedge Clock) begin
        done_q <= 1'b0;
        if (!nReset) begin
          state_q <= S_IDLE;
          step_q  <= '0;
          loop_q  <= '0;
          len_q   <= '0;
        end else if (!nStart[gi]) begin
          state_q <= S_PLAY;
          len_q   <= Loops[gi*LOOP_W +: LOOP_W];
          step_q  <= '0;
          loop_q  <= '0;
        end else if (!nStop[gi]) begin
          state_q <= S_IDLE;
          step_q  <= '0;
          loop_q  <= '0;
        end else if (Step && (state_q == S_PLAY)) begin
          if (step_q != LAST_STEP) begin
            step_q <= step_q + 1'b1;
          end else begin
            step_q <= '0;
            // Final loop keeps its index so the completed count stays visible
            if ((len_q != '0) && (loop_q == len_q - 1'b1)) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end else begin
              loop_q <= loop_q + 1'b1;
            end
          end
        end
      end

      assign Play[gi]                        = (state_q == S_PLAY);
      assign Done[gi]                        = done_q;
      assign StepIdx[gi*SIDX_W +: SIDX_W]    = step_q;
      assign LoopIdx[gi*LOOP_W +: LOOP_W]    = loop_q;
    end
  endgenerate

endmodule

// File: tb/tb_multi_loop_counter.sv
// Directed bench for multi_loop_counter: start/stop/loop completion, forever
// play, priority corner cases and mid-play reset.
module tb_multi_loop_counter;
  localparam int CH     = 4;
  localparam int STEPS  = 16;
  localparam int LOOP_W = 8;
  localparam int SIDX_W = 4;

  logic                 Clock = 1'b0;
  logic                 nReset;
  logic                 Step;
  logic [CH-1:0]        nStart;
  logic [CH-1:0]        nStop;
  logic [CH*LOOP_W-1:0] Loops;
  logic [CH-1:0]        Play;
  logic [CH*SIDX_W-1:0] StepIdx;
  logic [CH*LOOP_W-1:0] LoopIdx;
  logic [CH-1:0]        Done;

  int checks   = 0;
  int failures = 0;
  logic [CH-1:0] done_seen;

  multi_loop_counter #(.CH(CH), .STEPS(STEPS), .LOOP_W(LOOP_W)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .Step   (Step),
    .nStart (nStart),
    .nStop  (nStop),
    .Loops  (Loops),
    .Play   (Play),
    .StepIdx(StepIdx),
    .LoopIdx(LoopIdx),
    .Done   (Done)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    done_seen = done_seen | Done;
  endtask

  task automatic step_n(input int n);
    Step = 1'b1;
    for (int i = 0; i < n; i++) tick();
    Step = 1'b0;
  endtask

  function automatic logic [31:0] sidx(input int c);
    return 32'(StepIdx[c*SIDX_W +: SIDX_W]);
  endfunction

  function automatic logic [31:0] lidx(input int c);
    return 32'(LoopIdx[c*LOOP_W +: LOOP_W]);
  endfunction

  task automatic set_loops(input int c, input int v);
    Loops[c*LOOP_W +: LOOP_W] = LOOP_W'(v);
  endtask

  task automatic start(input int c);
    nStart[c] = 1'b0;
    tick();
    nStart[c] = 1'b1;
  endtask

  initial begin
    nReset = 1'b0; Step = 1'b0; nStart = '1; nStop = '1; Loops = '0; done_seen = '0;
    tick(); tick();
    chk("rst_play", 32'(Play), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_sidx", 32'(StepIdx), 0);
    chk("rst_lidx", 32'(LoopIdx), 0);

    // Step alone never leaves IDLE
    nReset = 1'b1;
    step_n(3);
    chk("idle_play", 32'(Play), 0);
    chk("idle_sidx", 32'(StepIdx), 0);

    // Channel 0, two loops: 32 steps total
    set_loops(0, 2);
    start(0);
    chk("c0_start", 32'(Play[0]), 1);
    chk("c0_sidx0", sidx(0), 0);
    done_seen = '0;
    step_n(31);
    chk("c0_play31", 32'(Play[0]), 1);
    chk("c0_sidx31", sidx(0), 15);
    chk("c0_lidx31", lidx(0), 1);
    chk("c0_nodone", 32'(done_seen[0]), 0);
    step_n(1);
    chk("c0_play32", 32'(Play[0]), 0);
    chk("c0_done", 32'(Done[0]), 1);
    chk("c0_sidx32", sidx(0), 0);
    chk("c0_lidx32", lidx(0), 1);
    tick();
    chk("c0_done1cy", 32'(Done[0]), 0);

    // Channel 1 loops forever
    set_loops(1, 0);
    start(1);
    done_seen = '0;
    step_n(300);
    chk("c1_play", 32'(Play[1]), 1);
    chk("c1_lidx", lidx(1), 18);
    chk("c1_sidx", sidx(1), 12);
    chk("c1_nodone", 32'(done_seen), 0);
    chk("c0_hold", lidx(0), 1);
    nStop[1] = 1'b0;
    tick();
    nStop[1] = 1'b1;
    chk("c1_stop", 32'(Play[1]), 0);
    chk("c1_stop_l", lidx(1), 0);

    // Channel 2 aborted after 20 steps
    set_loops(2, 3);
    start(2);
    step_n(20);
    chk("c2_sidx20", sidx(2), 4);
    chk("c2_lidx20", lidx(2), 1);
    done_seen = '0;
    nStop[2] = 1'b0;
    tick();
    nStop[2] = 1'b1;
    chk("c2_play", 32'(Play[2]), 0);
    chk("c2_sidx", sidx(2), 0);
    chk("c2_lidx", lidx(2), 0);
    step_n(50);
    chk("c2_ign", sidx(2), 0);
    chk("c2_nodone", 32'(done_seen), 0);

    // Start wins over Step; held start keeps counters at 0; latched length
    set_loops(0, 1);
    nStart[0] = 1'b0;
    Step = 1'b1;
    tick();
    chk("c0_ss_sidx", sidx(0), 0);
    tick(); tick();
    chk("c0_hold_s", sidx(0), 0);
    chk("c0_hold_p", 32'(Play[0]), 1);
    nStart[0] = 1'b1;
    Step = 1'b0;
    tick();
    set_loops(0, 5);
    step_n(15);
    chk("c0_l1_play", 32'(Play[0]), 1);
    chk("c0_l1_sidx", sidx(0), 15);
    step_n(1);
    chk("c0_l1_end", 32'(Play[0]), 0);
    chk("c0_l1_done", 32'(Done[0]), 1);

    // Start beats stop in the same cycle
    set_loops(3, 1);
    nStart[3] = 1'b0;
    nStop[3]  = 1'b0;
    tick();
    nStart[3] = 1'b1;
    nStop[3]  = 1'b1;
    chk("c3_prio", 32'(Play[3]), 1);

    // Reset mid-play overrides Step and start
    set_loops(0, 2);
    start(0);
    step_n(5);
    chk("two_play", 32'(Play), 32'h9);
    nReset = 1'b0;
    Step = 1'b1;
    nStart[1] = 1'b0;
    tick();
    nReset = 1'b1;
    nStart[1] = 1'b1;
    Step = 1'b0;
    chk("mr_play", 32'(Play), 0);
    chk("mr_sidx", 32'(StepIdx), 0);
    chk("mr_lidx", 32'(LoopIdx), 0);
    chk("mr_done", 32'(Done), 0);
    step_n(10);
    chk("mr_idle_p", 32'(Play), 0);
    chk("mr_idle_s", 32'(StepIdx), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
